// File: rtl/l1i_refill_controller_pkg.sv
// Shared L1I refill definitions: line geometry, refill FSM states, latched miss entry.
package l1i_refill_controller_pkg;

  localparam int unsigned OFFSET_SIZE    = 5;
  localparam int unsigned INDEX_SIZE     = 8;
  localparam int unsigned ADDR_WIDTH     = 64;
  localparam int unsigned TAG_SIZE       = ADDR_WIDTH - (OFFSET_SIZE + INDEX_SIZE);
  localparam int unsigned MEM_WIDTH      = 64;
  localparam int unsigned BEATS_PER_LINE = ((2 ** OFFSET_SIZE) * 8) / MEM_WIDTH;
  localparam int unsigned BEAT_BITS      = $clog2(BEATS_PER_LINE);
  // Stored tag entry layout: bit 0 is the valid flag, the tag sits above it.
  localparam int unsigned VALID_BIT      = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_FILL,
    ST_TAGWR
  } refill_state_e;

  typedef struct packed {
    logic [TAG_SIZE-1:0]   tag;
    logic [INDEX_SIZE-1:0] index;
  } miss_entry_t;

  // Line-aligned memory address for a latched miss.
  function automatic logic [ADDR_WIDTH-1:0] line_addr(input miss_entry_t e);
    return {e.tag, e.index, OFFSET_SIZE'(0)};
  endfunction

endpackage

// File: rtl/l1i_refill_controller_tag_compare.sv
// Combinational hit/miss classification of a tag query result.
//   lookup_valid : query result valid (already gated by the caller)
//   lookup_tag   : requested tag
//   queried_tag  : stored entry {tag, valid}
//   hit_c/miss_c : classification, both low when lookup_valid is low
module l1i_refill_controller_tag_compare
  import l1i_refill_controller_pkg::*;
(
  input  logic                lookup_valid,
  input  logic [TAG_SIZE-1:0] lookup_tag,
  input  logic [TAG_SIZE:0]   queried_tag,
  output logic                hit_c,
  output logic                miss_c
);

  logic tag_match_c;

  assign tag_match_c = queried_tag[VALID_BIT] &&
                       (queried_tag[TAG_SIZE:VALID_BIT+1] == lookup_tag);
  assign hit_c       = lookup_valid & tag_match_c;
  assign miss_c      = lookup_valid & ~tag_match_c;

endmodule

// File: rtl/l1i_refill_controller.sv
// L1I miss handler: classifies tag query results, stalls fetch on a miss,
// bursts the line from memory into the data array, then writes the new tag.
//   clock_i/reset_i         : clock, async active-high reset
//   lookup*_i, queriedTag_i : tag query result (hit_o comb, miss_o registered pulse)
//   stall_o                 : fetch hold while a refill is in flight
//   memReq_o/memAddr_o/memAck_i, memDataValid_i/memData_i : line read interface
//   lineWr*_o               : data-array beat writes (same cycle as memDataValid_i)
//   newTag_o/newIndex_o/updateEnable_o/refillDone_o : tag write-back
module l1i_refill_controller
  import l1i_refill_controller_pkg::*;
(
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   lookupValid_i,
  input  logic [TAG_SIZE-1:0]    lookupTag_i,
  input  logic [TAG_SIZE:0]      queriedTag_i,
  input  logic [INDEX_SIZE-1:0]  lookupIndex_i,
  input  logic [OFFSET_SIZE-1:0] lookupOffset_i,
  output logic                   hit_o,
  output logic                   miss_o,
  output logic                   stall_o,
  output logic                   memReq_o,
  output logic [ADDR_WIDTH-1:0]  memAddr_o,
  input  logic                   memAck_i,
  input  logic                   memDataValid_i,
  input  logic [MEM_WIDTH-1:0]   memData_i,
  output logic                   lineWrEnable_o,
  output logic [INDEX_SIZE-1:0]  lineWrIndex_o,
  output logic [BEAT_BITS-1:0]   lineWrBeat_o,
  output logic [MEM_WIDTH-1:0]   lineWrData_o,
  output logic [TAG_SIZE-1:0]    newTag_o,
  output logic [INDEX_SIZE-1:0]  newIndex_o,
  output logic                   updateEnable_o,
  output logic                   refillDone_o
);

  refill_state_e          state_q, state_d;
  logic [BEAT_BITS-1:0]   beat_q, beat_d;
  miss_entry_t            entry_q, entry_d;
  logic                   miss_q, miss_d;
  logic                   idle_c;
  logic                   lookup_hit_c;
  logic                   lookup_miss_c;
  logic                   line_wr_c;
  logic                   tag_wr_c;
  logic                   unused_offset;

  // The offset only matters to the data read path, not to refill.
  assign unused_offset = ^lookupOffset_i;

  assign idle_c = (state_q == ST_IDLE);

  // Lookups outside IDLE are dropped; fetch re-issues once the stall clears.
  l1i_refill_controller_tag_compare u_tag_compare (
    .lookup_valid (lookupValid_i & idle_c),
    .lookup_tag   (lookupTag_i),
    .queried_tag  (queriedTag_i),
    .hit_c        (lookup_hit_c),
    .miss_c       (lookup_miss_c)
  );

  // State, beat counter and latched miss entry.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      entry_q <= '0;
      miss_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      entry_q <= entry_d;
      miss_q  <= miss_d;
    end
  end

  // Next-state logic; the beat counter wraps to 0 on the last beat.
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    entry_d   = entry_q;
    miss_d    = 1'b0;
    line_wr_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (lookup_miss_c) begin
          entry_d = '{tag: lookupTag_i, index: lookupIndex_i};
          miss_d  = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        // A beat arriving with the ack is not consumed here.
        if (memAck_i) begin
          state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        if (memDataValid_i) begin
          line_wr_c = 1'b1;
          beat_d    = beat_q + BEAT_BITS'(1);
          if (beat_q == BEAT_BITS'(BEATS_PER_LINE - 1)) begin
            state_d = ST_TAGWR;
          end
        end
      end
      ST_TAGWR: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign tag_wr_c = (state_q == ST_TAGWR);

  assign hit_o          = lookup_hit_c;
  assign miss_o         = miss_q;
  assign stall_o        = ~idle_c;
  assign memReq_o       = (state_q == ST_REQ);
  assign memAddr_o      = memReq_o ? line_addr(entry_q) : '0;

  assign lineWrEnable_o = line_wr_c;
  assign lineWrIndex_o  = line_wr_c ? entry_q.index : '0;
  assign lineWrBeat_o   = line_wr_c ? beat_q : '0;
  assign lineWrData_o   = line_wr_c ? memData_i : '0;

  // Tag memory ORs these into its write port, so they must be 0 when idle.
  assign newTag_o       = tag_wr_c ? entry_q.tag : '0;
  assign newIndex_o     = tag_wr_c ? entry_q.index : '0;
  assign updateEnable_o = tag_wr_c;
  assign refillDone_o   = tag_wr_c;

endmodule

// File: tb/tb_l1i_refill_controller.sv
// Self-checking bench for l1i_refill_controller: scoreboarded beat and tag writes.
module tb_l1i_refill_controller;
  import l1i_refill_controller_pkg::*;

  logic                   clock_i = 1'b0;
  logic                   reset_i;
  logic                   lookupValid_i;
  logic [TAG_SIZE-1:0]    lookupTag_i;
  logic [TAG_SIZE:0]      queriedTag_i;
  logic [INDEX_SIZE-1:0]  lookupIndex_i;
  logic [OFFSET_SIZE-1:0] lookupOffset_i;
  logic                   hit_o;
  logic                   miss_o;
  logic                   stall_o;
  logic                   memReq_o;
  logic [ADDR_WIDTH-1:0]  memAddr_o;
  logic                   memAck_i;
  logic                   memDataValid_i;
  logic [MEM_WIDTH-1:0]   memData_i;
  logic                   lineWrEnable_o;
  logic [INDEX_SIZE-1:0]  lineWrIndex_o;
  logic [BEAT_BITS-1:0]   lineWrBeat_o;
  logic [MEM_WIDTH-1:0]   lineWrData_o;
  logic [TAG_SIZE-1:0]    newTag_o;
  logic [INDEX_SIZE-1:0]  newIndex_o;
  logic                   updateEnable_o;
  logic                   refillDone_o;

  typedef struct packed {
    logic [INDEX_SIZE-1:0] idx;
    logic [BEAT_BITS-1:0]  beat;
    logic [MEM_WIDTH-1:0]  data;
  } wr_exp_t;

  typedef struct packed {
    logic [TAG_SIZE-1:0]   tag;
    logic [INDEX_SIZE-1:0] idx;
  } tu_exp_t;

  wr_exp_t     wr_q[$];
  tu_exp_t     tu_q[$];
  int unsigned vec_cnt = 0;
  int unsigned err_cnt = 0;

  l1i_refill_controller dut (
    .clock_i        (clock_i),
    .reset_i        (reset_i),
    .lookupValid_i  (lookupValid_i),
    .lookupTag_i    (lookupTag_i),
    .queriedTag_i   (queriedTag_i),
    .lookupIndex_i  (lookupIndex_i),
    .lookupOffset_i (lookupOffset_i),
    .hit_o          (hit_o),
    .miss_o         (miss_o),
    .stall_o        (stall_o),
    .memReq_o       (memReq_o),
    .memAddr_o      (memAddr_o),
    .memAck_i       (memAck_i),
    .memDataValid_i (memDataValid_i),
    .memData_i      (memData_i),
    .lineWrEnable_o (lineWrEnable_o),
    .lineWrIndex_o  (lineWrIndex_o),
    .lineWrBeat_o   (lineWrBeat_o),
    .lineWrData_o   (lineWrData_o),
    .newTag_o       (newTag_o),
    .newIndex_o     (newIndex_o),
    .updateEnable_o (updateEnable_o),
    .refillDone_o   (refillDone_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every data-array write and tag write must match a queued expectation.
  always @(negedge clock_i) begin
    wr_exp_t we;
    tu_exp_t te;
    if (!reset_i) begin
      if (lineWrEnable_o) begin
        if (wr_q.size() == 0) begin
          chk("wr_unexpected", 64'd1, 64'd0);
        end else begin
          we = wr_q.pop_front();
          chk("wr_index", 64'(lineWrIndex_o), 64'(we.idx));
          chk("wr_beat",  64'(lineWrBeat_o),  64'(we.beat));
          chk("wr_data",  64'(lineWrData_o),  64'(we.data));
        end
      end
      if (updateEnable_o) begin
        if (tu_q.size() == 0) begin
          chk("upd_unexpected", 64'd1, 64'd0);
        end else begin
          te = tu_q.pop_front();
          chk("upd_tag",   64'(newTag_o),   64'(te.tag));
          chk("upd_index", 64'(newIndex_o), 64'(te.idx));
        end
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_hit"},     64'(hit_o),          64'd0);
    chk({tag, "_miss"},    64'(miss_o),         64'd0);
    chk({tag, "_stall"},   64'(stall_o),        64'd0);
    chk({tag, "_memreq"},  64'(memReq_o),       64'd0);
    chk({tag, "_memaddr"}, 64'(memAddr_o),      64'd0);
    chk({tag, "_wren"},    64'(lineWrEnable_o), 64'd0);
    chk({tag, "_wridx"},   64'(lineWrIndex_o),  64'd0);
    chk({tag, "_wrbeat"},  64'(lineWrBeat_o),   64'd0);
    chk({tag, "_wrdata"},  64'(lineWrData_o),   64'd0);
    chk({tag, "_newtag"},  64'(newTag_o),       64'd0);
    chk({tag, "_newidx"},  64'(newIndex_o),     64'd0);
    chk({tag, "_upd"},     64'(updateEnable_o), 64'd0);
    chk({tag, "_done"},    64'(refillDone_o),   64'd0);
  endtask

  // One full miss: lookup, request (optionally delayed ack), beat pattern, tag write.
  // abort_after > 0 asserts reset once that many beats have been written.
  task automatic run_miss(input logic [TAG_SIZE-1:0] tg, input logic [INDEX_SIZE-1:0] ix,
                          input logic qv, input logic [TAG_SIZE-1:0] qt,
                          input int ack_delay, input bit coincide,
                          input logic [15:0] pat, input int npat,
                          input bit fill_lookup, input int abort_after);
    int                    beat_n;
    logic [MEM_WIDTH-1:0]  d;
    logic [ADDR_WIDTH-1:0] exp_addr;
    beat_n   = 0;
    exp_addr = {tg, ix, 5'b0};

    @(posedge clock_i); #1;
    lookupValid_i  = 1'b1;
    lookupTag_i    = tg;
    queriedTag_i   = {qt, qv};
    lookupIndex_i  = ix;
    lookupOffset_i = 5'h1c;
    @(negedge clock_i);
    chk("miss_lookup_hit", 64'(hit_o), 64'd0);
    chk("miss_pre_stall",  64'(stall_o), 64'd0);

    @(posedge clock_i); #1;
    lookupValid_i = 1'b0;
    @(negedge clock_i);
    chk("miss_pulse",  64'(miss_o),   64'd1);
    chk("req_stall",   64'(stall_o),  64'd1);
    chk("req_memreq",  64'(memReq_o), 64'd1);
    chk("req_memaddr", memAddr_o,     exp_addr);

    for (int i = 0; i < ack_delay; i++) begin
      @(posedge clock_i); #1;
      memDataValid_i = 1'b1;
      memData_i      = {$urandom, $urandom};
      @(negedge clock_i);
      chk("wait_memreq",  64'(memReq_o),       64'd1);
      chk("wait_memaddr", memAddr_o,           exp_addr);
      chk("wait_wren",    64'(lineWrEnable_o), 64'd0);
      chk("wait_miss",    64'(miss_o),         64'd0);
    end

    @(posedge clock_i); #1;
    memAck_i       = 1'b1;
    memDataValid_i = coincide;
    memData_i      = {$urandom, $urandom};
    @(negedge clock_i);
    chk("ack_memreq", 64'(memReq_o),       64'd1);
    chk("ack_wren",   64'(lineWrEnable_o), 64'd0);

    for (int c = 0; c < npat; c++) begin
      @(posedge clock_i); #1;
      memAck_i       = 1'b0;
      memDataValid_i = pat[c];
      d              = {$urandom, $urandom};
      memData_i      = d;
      lookupValid_i  = fill_lookup;
      lookupTag_i    = tg;
      queriedTag_i   = {tg, 1'b1};
      if (pat[c]) begin
        wr_q.push_back('{ix, BEAT_BITS'(beat_n), d});
        beat_n++;
        if (beat_n == 4 && abort_after == 0) tu_q.push_back('{tg, ix});
      end
      @(negedge clock_i);
      chk("fill_wren",   64'(lineWrEnable_o), 64'(pat[c]));
      chk("fill_stall",  64'(stall_o),        64'd1);
      chk("fill_memreq", 64'(memReq_o),       64'd0);
      chk("fill_newtag", 64'(newTag_o),       64'd0);
      chk("fill_upd",    64'(updateEnable_o), 64'd0);
      if (fill_lookup) begin
        chk("fill_hit",  64'(hit_o),  64'd0);
        chk("fill_miss", 64'(miss_o), 64'd0);
      end
      if (abort_after > 0 && beat_n == abort_after) break;
    end

    @(posedge clock_i); #1;
    memAck_i       = 1'b0;
    memDataValid_i = 1'b0;
    lookupValid_i  = 1'b0;
    if (abort_after > 0) begin
      reset_i = 1'b1;
      @(negedge clock_i);
      chk_all_zero("abort");
      @(posedge clock_i); #1;
      reset_i = 1'b0;
      @(negedge clock_i);
      chk_all_zero("post_abort");
    end else begin
      @(negedge clock_i);
      chk("tagwr_upd",    64'(updateEnable_o), 64'd1);
      chk("tagwr_done",   64'(refillDone_o),   64'd1);
      chk("tagwr_newtag", 64'(newTag_o),       64'(tg));
      chk("tagwr_newidx", 64'(newIndex_o),     64'(ix));
      chk("tagwr_stall",  64'(stall_o),        64'd1);
      @(posedge clock_i); #1;
      @(negedge clock_i);
      chk("end_stall",  64'(stall_o),        64'd0);
      chk("end_upd",    64'(updateEnable_o), 64'd0);
      chk("end_newtag", 64'(newTag_o),       64'd0);
      chk("end_newidx", 64'(newIndex_o),     64'd0);
      chk("end_memreq", 64'(memReq_o),       64'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_i        = 1'b1;
    lookupValid_i  = 1'b0;
    lookupTag_i    = '0;
    queriedTag_i   = '0;
    lookupIndex_i  = '0;
    lookupOffset_i = '0;
    memAck_i       = 1'b0;
    memDataValid_i = 1'b0;
    memData_i      = '0;

    repeat (2) @(posedge clock_i);
    @(negedge clock_i);
    chk_all_zero("reset");
    @(posedge clock_i); #1;
    reset_i = 1'b0;

    // Hit: no miss, no stall, no request.
    @(posedge clock_i); #1;
    lookupValid_i = 1'b1;
    lookupTag_i   = 51'h1234;
    queriedTag_i  = {51'h1234, 1'b1};
    lookupIndex_i = 8'h40;
    @(negedge clock_i);
    chk("hit_hit",   64'(hit_o),   64'd1);
    chk("hit_stall", 64'(stall_o), 64'd0);
    @(posedge clock_i); #1;
    lookupValid_i = 1'b0;
    @(negedge clock_i);
    chk("hit_miss",   64'(miss_o),   64'd0);
    chk("hit_memreq", 64'(memReq_o), 64'd0);
    chk("hit_stall2", 64'(stall_o),  64'd0);
    chk("hit_novld",  64'(hit_o),    64'd0);

    // Cold miss: matching tag but invalid entry; address 0xA200.
    run_miss(51'h5, 8'h10, 1'b0, 51'h5, 0, 1'b0, 16'h000f, 4, 1'b0, 0);
    // Conflict miss, ack delayed 5 cycles with stray beats, ack coincident with a beat.
    run_miss(51'h8, 8'h22, 1'b1, 51'h7, 5, 1'b1, 16'h000f, 4, 1'b0, 0);
    // Gapped beats on fill cycles 0,2,3,7 with matching lookups during fill.
    run_miss(51'h3abc, 8'hff, 1'b1, 51'h1, 1, 1'b0, 16'h008d, 8, 1'b1, 0);
    // Reset after beat 1 is written, then a clean refill restarts at beat 0.
    run_miss(51'h99, 8'h01, 1'b0, 51'h0, 0, 1'b0, 16'h000f, 4, 1'b0, 2);
    run_miss(51'h99, 8'h01, 1'b0, 51'h0, 2, 1'b0, 16'h000f, 4, 1'b0, 0);

    repeat (2) @(posedge clock_i);
    @(negedge clock_i);
    chk("sb_wr_left",  64'(wr_q.size()), 64'd0);
    chk("sb_upd_left", 64'(tu_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
